rtc_write_seq: RTL and testbench
================================

// Module: rtc_write_seq
// PURPOSE
//  Write-back end of the RTC interface. After the user edits the BCD time/date holding registers
//  (sec..year), a start pulse snapshots all six values. The block then drives the RTC's
//  multiplexed address/data bus: one address-phase write plus one data-phase write per register.
//  It sits between the edit/holding registers and the RTC pad drivers; the read path is a separate block.
// PARAMETERS
//  T_SETUP  2  cycles: AD/AD_n valid, CS_n low, before WR_n falls (>=1)
//  T_PULSE  4  cycles: WR_n held low (>=1)
//  T_HOLD   2  cycles: WR_n high, AD still driven, before the next phase (>=1)
// PORTS
//  CLK      in   1  system clock, rising edge
//  RST      in   1  asynchronous reset, active-high
//  START    in   1  1-cycle request to write all six registers
//  SEC,MIN,HOUR,DAY,MONTH,YEAR  in  8 each  BCD values to write
//  BUSY     out  1  high from the cycle after an accepted START until DONE
//  DONE     out  1  1-cycle pulse when the sequence ends
//  ERR      out  1  1-cycle pulse with DONE when the sequence is aborted (see CONFIGURATION)
//  AD_out   out  8  address or data byte on the RTC bus
//  AD_oe    out  1  bus drive enable (1 = block drives AD)
//  AD_n     out  1  0 = address phase, 1 = data phase
//  CS_n, WR_n, RD_n  out  1  RTC strobes, active-low; RD_n is always 1
// BEHAVIOUR
//  - Reset, async: state IDLE, index 0, BUSY/DONE/ERR/AD_oe = 0, AD_out = 0, CS_n/WR_n/RD_n/AD_n = 1.
//    Reset mid-sequence releases the bus in the same edge; no partial phase completes.
//  - All outputs are registered.
//  - IDLE + START = 1: snapshot the six inputs, index = 0, go to A_SETUP, BUSY = 1.
//    START while BUSY is ignored. Input changes after the snapshot do not affect the sequence.
//  - FSM: IDLE -> A_SETUP -> A_WR -> A_HOLD -> D_SETUP -> D_WR -> D_HOLD -> (index<5 ? A_SETUP : FIN) -> IDLE.
//    Each phase state lasts its parameter in cycles; a shared down-counter (width clog2 of the
//    maximum parameter + 1) is loaded on phase entry.
//  - A_*: AD_n = 0, AD_out = ADDR[index]. D_*: AD_n = 1, AD_out = snapshot[index].
//  - *_SETUP and *_HOLD: CS_n = 0, WR_n = 1. *_WR: CS_n = 0, WR_n = 0. AD_oe = 1 in all six phase states.
//  - CS_n and AD_oe rise only in FIN and IDLE.
//  - Index order is 0..5 = sec, min, hour, day, month, year. Index increments on D_HOLD exit; no wrap.
//  - FIN (1 cycle): DONE = 1, BUSY = 0 on the next edge, bus released.
//  - Latency from START to DONE = 6 * 2 * (T_SETUP + T_PULSE + T_HOLD) + 1 cycles (97 with defaults).
// CONFIGURATION
//  `BCD_CHECK_EN defined: in the cycle after START, check every snapshot nibble.
//    If any nibble is > 9, no bus activity occurs; go straight to FIN with DONE = 1 and ERR = 1 (total 2 cycles).
//  Not defined: no check, values are written as-is, ERR is tied to 0.
// STRUCTURE
//  rtc_pkg: register addresses (RTC_A_SEC=8'h21, MIN=8'h22, HOUR=8'h23, DAY=8'h24, MONTH=8'h25,
//    YEAR=8'h26), state encoding localparams, NUM_REGS = 6.
//  Sub-module rtc_bus_wr_phase: one SETUP/WR/HOLD phase with its counter (go in; phase_done out;
//    CS_n, WR_n out). It is instantiated once and reused for address and data phases.
// TESTING
//  1 Defaults, START with sec=8'h45 min=8'h30 hour=8'h12 day=8'h07 month=8'h11 year=8'h22 ->
//    12 WR_n pulses, each 4 cycles low; AD_out = 21,45,22,30,...,26,22; DONE at cycle 97.
//  2 Change YEAR to 8'h99 on the cycle after START -> bus still carries 8'h22 for the year data phase.
//  3 START pulsed again at cycles 5 and 50 -> ignored; exactly 12 WR_n pulses; one DONE.
//  4 RST asserted during the D_WR phase of hour -> same-edge CS_n = WR_n = 1, AD_oe = 0;
//    a new START restarts from sec.
//  5 `BCD_CHECK_EN, month = 8'h1A -> DONE and ERR high 2 cycles after START; CS_n never low.
//  6 T_SETUP = T_PULSE = T_HOLD = 1 -> 6-cycle register period; DONE at cycle 37.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC write-back path: register addresses,
// sequencer/phase state encodings and small helpers.
package rtc_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [7:0] RTC_A_SEC   = 8'h21;
  localparam logic [7:0] RTC_A_MIN   = 8'h22;
  localparam logic [7:0] RTC_A_HOUR  = 8'h23;
  localparam logic [7:0] RTC_A_DAY   = 8'h24;
  localparam logic [7:0] RTC_A_MONTH = 8'h25;
  localparam logic [7:0] RTC_A_YEAR  = 8'h26;

  // Top-level sequencer: address phase / data phase per register.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ADDR,
    ST_DATA,
    ST_FIN
  } seq_state_t;

  // One bus write phase: SETUP -> WR -> HOLD.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_WR,
    PH_HOLD
  } phase_state_t;

  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return RTC_A_SEC;
      3'd1:    return RTC_A_MIN;
      3'd2:    return RTC_A_HOUR;
      3'd3:    return RTC_A_DAY;
      3'd4:    return RTC_A_MONTH;
      3'd5:    return RTC_A_YEAR;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_wr_phase.sv
// One RTC bus write phase: SETUP (CS_n low, WR_n high), WR (WR_n low),
// HOLD (WR_n high). A go pulse starts a phase; a go coinciding with
// phase_done chains the next phase without releasing CS_n.
// Ports:
//   CLK, RST    clock, async active-high reset
//   go          start (or chain) a phase
//   phase_done  high in the last HOLD cycle
//   CS_n, WR_n  registered RTC strobes
module rtc_bus_wr_phase
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic go,
  output logic phase_done,
  output logic CS_n,
  output logic WR_n
);

  localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX    = (T_MAX_SP > T_HOLD) ? T_MAX_SP : T_HOLD;
  localparam int CW       = $clog2(T_MAX + 1);

  phase_state_t  state;
  logic [CW-1:0] cnt;

  assign phase_done = (state == PH_HOLD) && (cnt == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= PH_IDLE;
      cnt   <= '0;
      CS_n  <= 1'b1;
      WR_n  <= 1'b1;
    end else begin
      case (state)
        PH_IDLE: begin
          if (go) begin
            state <= PH_SETUP;
            cnt   <= CW'(T_SETUP - 1);
            CS_n  <= 1'b0;
            WR_n  <= 1'b1;
          end
        end
        PH_SETUP: begin
          if (cnt == '0) begin
            state <= PH_WR;
            cnt   <= CW'(T_PULSE - 1);
            WR_n  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_WR: begin
          if (cnt == '0) begin
            state <= PH_HOLD;
            cnt   <= CW'(T_HOLD - 1);
            WR_n  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_HOLD: begin
          if (cnt == '0) begin
            if (go) begin
              state <= PH_SETUP;
              cnt   <= CW'(T_SETUP - 1);
            end else begin
              state <= PH_IDLE;
              CS_n  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= PH_IDLE;
          CS_n  <= 1'b1;
          WR_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_write_seq.sv
// RTC write-back sequencer. START snapshots SEC..YEAR, then writes each
// register as an address phase followed by a data phase on the multiplexed
// AD bus. DONE pulses at the end; all outputs are registered.
// Optional feature: define BCD_CHECK_EN to validate every snapshot nibble in
// the cycle after START; an invalid nibble aborts with DONE+ERR and no bus
// activity. Without it, ERR stays 0.
// Ports:
//   CLK, RST                     clock, async active-high reset
//   START                        1-cycle write request (ignored while busy)
//   SEC,MIN,HOUR,DAY,MONTH,YEAR  BCD values to write
//   BUSY, DONE, ERR              status
//   AD_out, AD_oe, AD_n          bus byte, drive enable, 0=address/1=data
//   CS_n, WR_n, RD_n             RTC strobes (RD_n always 1)
module rtc_write_seq
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] SEC,
  input  logic [7:0] MIN,
  input  logic [7:0] HOUR,
  input  logic [7:0] DAY,
  input  logic [7:0] MONTH,
  input  logic [7:0] YEAR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       AD_n,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n
);

  seq_state_t state;
  logic [2:0] idx;
  logic [7:0] snap [NUM_REGS];
  logic       go;
  logic       start_go;
  logic       phase_done;
  logic       last_reg;

  assign last_reg = (idx == 3'(NUM_REGS - 1));

`ifdef BCD_CHECK_EN
  logic snap_ok;

  always_comb begin
    snap_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      snap_ok = snap_ok & is_bcd(snap[i]);
    end
  end

  assign start_go = (state == ST_CHECK) && snap_ok;
`else
  assign start_go = (state == ST_IDLE) && START;
`endif

  // The SETUP/WR/HOLD timing lives in the phase sub-module; this FSM only
  // tracks address vs data phase. go is combinational so the phase starts
  // on the same edge that the sequencer moves, keeping CS_n low between
  // back-to-back phases.
  assign go = start_go || (phase_done && !((state == ST_DATA) && last_reg));

  rtc_bus_wr_phase #(
    .T_SETUP(T_SETUP),
    .T_PULSE(T_PULSE),
    .T_HOLD (T_HOLD)
  ) u_phase (
    .CLK       (CLK),
    .RST       (RST),
    .go        (go),
    .phase_done(phase_done),
    .CS_n      (CS_n),
    .WR_n      (WR_n)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      idx    <= '0;
      snap   <= '{default: '0};
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      AD_out <= '0;
      AD_oe  <= 1'b0;
      AD_n   <= 1'b1;
      RD_n   <= 1'b1;
    end else begin
      RD_n <= 1'b1;
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            snap <= '{SEC, MIN, HOUR, DAY, MONTH, YEAR};
            idx  <= '0;
            BUSY <= 1'b1;
`ifdef BCD_CHECK_EN
            state <= ST_CHECK;
`else
            state  <= ST_ADDR;
            AD_oe  <= 1'b1;
            AD_n   <= 1'b0;
            AD_out <= reg_addr(3'd0);
`endif
          end
        end
`ifdef BCD_CHECK_EN
        ST_CHECK: begin
          if (snap_ok) begin
            state  <= ST_ADDR;
            AD_oe  <= 1'b1;
            AD_n   <= 1'b0;
            AD_out <= reg_addr(3'd0);
          end else begin
            state <= ST_FIN;
          end
        end
`endif
        ST_ADDR: begin
          if (phase_done) begin
            state  <= ST_DATA;
            AD_n   <= 1'b1;
            AD_out <= snap[idx];
          end
        end
        ST_DATA: begin
          if (phase_done) begin
            if (last_reg) begin
              state  <= ST_FIN;
              AD_oe  <= 1'b0;
              AD_n   <= 1'b1;
              AD_out <= '0;
            end else begin
              state  <= ST_ADDR;
              idx    <= idx + 3'd1;
              AD_n   <= 1'b0;
              AD_out <= reg_addr(idx + 3'd1);
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
`ifdef BCD_CHECK_EN
          ERR <= !snap_ok;
`endif
        end
        default: begin
          state  <= ST_IDLE;
          BUSY   <= 1'b0;
          AD_oe  <= 1'b0;
          AD_n   <= 1'b1;
          AD_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_seq.sv
// Bench for rtc_write_seq: default-timing instance and a 1/1/1 timing instance.
module tb_rtc_write_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [7:0] sec, min, hour, day, month, year;
  logic [1:0] busy_w, done_w, err_w, oe_w, adn_w, cs_w, wr_w, rd_w;
  logic [15:0] ad_w;

  int checks = 0;
  int errors = 0;

`ifdef BCD_CHECK_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  always #5 clk = ~clk;

  rtc_write_seq u_dut0 (
    .CLK(clk), .RST(rst), .START(start[0]),
    .SEC(sec), .MIN(min), .HOUR(hour), .DAY(day), .MONTH(month), .YEAR(year),
    .BUSY(busy_w[0]), .DONE(done_w[0]), .ERR(err_w[0]),
    .AD_out(ad_w[7:0]), .AD_oe(oe_w[0]), .AD_n(adn_w[0]),
    .CS_n(cs_w[0]), .WR_n(wr_w[0]), .RD_n(rd_w[0])
  );

  rtc_write_seq #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start[1]),
    .SEC(sec), .MIN(min), .HOUR(hour), .DAY(day), .MONTH(month), .YEAR(year),
    .BUSY(busy_w[1]), .DONE(done_w[1]), .ERR(err_w[1]),
    .AD_out(ad_w[15:8]), .AD_oe(oe_w[1]), .AD_n(adn_w[1]),
    .CS_n(cs_w[1]), .WR_n(wr_w[1]), .RD_n(rd_w[1])
  );

  typedef struct {
    logic [7:0] ad;
    logic       ad_n;
  } phase_t;

  typedef struct {
    int d;
    int s;
    int p;
    int per;
    bit chg;
    bit extra;
    int done_at;
  } scen_t;

  phase_t ph_tab [12];
  scen_t  sc_tab [4];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] ad_of(input int d);
    return (d == 1) ? ad_w[15:8] : ad_w[7:0];
  endfunction

  task automatic load_inputs();
    sec = 8'h45; min = 8'h30; hour = 8'h12;
    day = 8'h07; month = 8'h11; year = 8'h22;
  endtask

  task automatic check_idle(input int d, input string tag);
    chk1({tag, "_cs_n"},  cs_w[d],  1'b1);
    chk1({tag, "_wr_n"},  wr_w[d],  1'b1);
    chk1({tag, "_rd_n"},  rd_w[d],  1'b1);
    chk1({tag, "_ad_n"},  adn_w[d], 1'b1);
    chk1({tag, "_ad_oe"}, oe_w[d],  1'b0);
    chk8({tag, "_ad"},    ad_of(d), 8'h00);
    chk1({tag, "_busy"},  busy_w[d], 1'b0);
    chk1({tag, "_done"},  done_w[d], 1'b0);
    chk1({tag, "_err"},   err_w[d],  1'b0);
  endtask

  // Full sequence, sampled 1 ns after every rising edge; sample 0 follows
  // the edge that accepts START.
  task automatic run_seq(input scen_t sc);
    int   total;
    int   wr_falls;
    int   dones;
    int   j;
    int   ph;
    int   off;
    logic prev_wr;
    logic in_bus;
    total    = 12 * sc.per;
    wr_falls = 0;
    dones    = 0;
    prev_wr  = 1'b1;
    @(negedge clk);
    load_inputs();
    start[sc.d] = 1'b1;
    for (int k = 0; k <= sc.done_at + 1 + LAT; k++) begin
      @(posedge clk);
      #1;
      j      = k - LAT;
      in_bus = (j >= 0) && (j < total);
      if (in_bus) begin
        ph  = j / sc.per;
        off = j % sc.per;
        chk8("ad_out", ad_of(sc.d), ph_tab[ph].ad);
        chk1("ad_n", adn_w[sc.d], ph_tab[ph].ad_n);
        chk1("wr_n", wr_w[sc.d], !((off >= sc.s) && (off < sc.s + sc.p)));
      end else begin
        chk8("ad_out_rel", ad_of(sc.d), 8'h00);
        chk1("ad_n_rel", adn_w[sc.d], 1'b1);
        chk1("wr_n_rel", wr_w[sc.d], 1'b1);
      end
      chk1("cs_n", cs_w[sc.d], !in_bus);
      chk1("ad_oe", oe_w[sc.d], in_bus);
      chk1("busy", busy_w[sc.d], j < sc.done_at);
      chk1("done", done_w[sc.d], j == sc.done_at);
      chk1("err", err_w[sc.d], 1'b0);
      chk1("rd_n", rd_w[sc.d], 1'b1);
      if (prev_wr && !wr_w[sc.d]) wr_falls++;
      prev_wr = wr_w[sc.d];
      if (done_w[sc.d]) dones++;
      @(negedge clk);
      start[sc.d] = sc.extra && ((k == 4) || (k == 49));
      if (sc.chg && (k == 0)) year = 8'h99;
    end
    chki("wr_pulse_count", wr_falls, 12);
    chki("done_count", dones, 1);
  endtask

  initial begin
    ph_tab[0]  = '{8'h21, 1'b0};  ph_tab[1]  = '{8'h45, 1'b1};
    ph_tab[2]  = '{8'h22, 1'b0};  ph_tab[3]  = '{8'h30, 1'b1};
    ph_tab[4]  = '{8'h23, 1'b0};  ph_tab[5]  = '{8'h12, 1'b1};
    ph_tab[6]  = '{8'h24, 1'b0};  ph_tab[7]  = '{8'h07, 1'b1};
    ph_tab[8]  = '{8'h25, 1'b0};  ph_tab[9]  = '{8'h11, 1'b1};
    ph_tab[10] = '{8'h26, 1'b0};  ph_tab[11] = '{8'h22, 1'b1};

    //            d  s  p  per chg extra done_at
    sc_tab[0] = '{0, 2, 4, 8,  0,  0,    97};
    sc_tab[1] = '{0, 2, 4, 8,  1,  0,    97};
    sc_tab[2] = '{0, 2, 4, 8,  0,  1,    97};
    sc_tab[3] = '{1, 1, 1, 3,  0,  0,    37};

    rst   = 1'b1;
    start = '0;
    load_inputs();
    #12;
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_seq(sc_tab[i]);
      repeat (2) @(negedge clk);
    end

    // Reset during the hour data-phase WR pulse (samples 42..45 + LAT).
    @(negedge clk);
    load_inputs();
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (43 + LAT) @(posedge clk);
    #2;
    chk1("pre_rst_wr_n", wr_w[0], 1'b0);
    chk8("pre_rst_ad", ad_w[7:0], 8'h12);
    rst = 1'b1;
    #1;
    check_idle(0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    run_seq(sc_tab[0]);

`ifdef BCD_CHECK_EN
    @(negedge clk);
    load_inputs();
    month    = 8'h1A;
    start[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk1("bcd_cs_n", cs_w[0], 1'b1);
      chk1("bcd_ad_oe", oe_w[0], 1'b0);
      chk1("bcd_done", done_w[0], k == 2);
      chk1("bcd_err", err_w[0], k == 2);
      @(negedge clk);
      start[0] = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
